// File: rtl/alu_arbiter_pkg.sv
// Opcode set shared with the byte-slice alu, plus the latched-request record
// used by the arbiter.
package alu_arbiter_pkg;

  localparam int AC_N = 3;

  localparam logic [AC_N-1:0] AC_AD = 3'd0;
  localparam logic [AC_N-1:0] AC_SB = 3'd1;
  localparam logic [AC_N-1:0] AC_AN = 3'd2;
  localparam logic [AC_N-1:0] AC_OR = 3'd3;
  localparam logic [AC_N-1:0] AC_LS = 3'd4;

  typedef struct packed {
    logic [AC_N-1:0] op;
    logic [15:0]     a;
    logic [15:0]     b;
  } req_t;

  // Undefined encodings collapse to AND so the datapath never sees them.
  function automatic logic [AC_N-1:0] norm_op(input logic [AC_N-1:0] op);
    case (op)
      AC_AD, AC_SB, AC_AN, AC_OR, AC_LS: norm_op = op;
      default:                           norm_op = AC_AN;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter.sv
// Round-robin owner of the 8-bit alu: runs 16-bit ops as two byte passes
// (low then high, or high first for signed compare) and returns the result.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            req0,
  input  logic            req1,
  input  logic [AC_N-1:0] op0,
  input  logic [AC_N-1:0] op1,
  input  logic [15:0]     a0,
  input  logic [15:0]     b0,
  input  logic [15:0]     a1,
  input  logic [15:0]     b1,
  output logic            done0,
  output logic            done1,
  output logic [15:0]     res,
  output logic            res_zero,
  output logic            res_carry,
  output logic            res_cmp,
  output logic            busy,
  output logic [AC_N-1:0] alu_cs,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic            alu_cin,
  input  logic [7:0]      alu_s,
  input  logic            alu_zero,
  input  logic            alu_cout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALL = 2'd1;
  localparam logic [1:0] S_CALH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] state;
  logic       owner;
  logic       last_win;
  req_t       cur;
  logic       carry_q;
  logic       zlo_q;

  logic       win;
  req_t       nxt;
  logic       is_ls;

  // With both requests up, the one that did not win last time goes next.
  always_comb begin
    win    = (req0 & req1) ? ~last_win : req1;
    nxt.op = norm_op(win ? op1 : op0);
    nxt.a  = win ? a1 : a0;
    nxt.b  = win ? b1 : b0;
    is_ls  = (cur.op == AC_LS);
  end

  always_comb begin
    alu_cs  = '0;
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    case (state)
      S_CALL: begin
        alu_cs = cur.op;
        alu_a  = cur.a[7:0];
        alu_b  = cur.b[7:0];
      end
      S_CALH: begin
        alu_cs  = cur.op;
        alu_a   = cur.a[15:8];
        alu_b   = cur.b[15:8];
        alu_cin = is_ls ? 1'b0 : carry_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      last_win  <= 1'b1;
      cur       <= '0;
      carry_q   <= 1'b0;
      zlo_q     <= 1'b0;
      res       <= '0;
      res_zero  <= 1'b0;
      res_carry <= 1'b0;
      res_cmp   <= 1'b0;
      busy      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 | req1) begin
            owner    <= win;
            last_win <= win;
            cur      <= nxt;
            busy     <= 1'b1;
            state    <= (nxt.op == AC_LS) ? S_CALH : S_CALL;
          end
        end
        S_CALL: begin
          if (is_ls) begin
            res       <= {15'b0, alu_s[0]};
            res_cmp   <= alu_s[0];
            res_zero  <= 1'b0;
            res_carry <= 1'b0;
            state     <= S_DONE;
          end else begin
            res[7:0] <= alu_s;
            zlo_q    <= alu_zero;
            carry_q  <= alu_cout;
            state    <= S_CALH;
          end
        end
        S_CALH: begin
          if (is_ls) begin
            res_zero  <= 1'b0;
            res_carry <= 1'b0;
            // Sign difference decides a signed compare on its own.
            if (cur.a[15] != cur.b[15]) begin
              res     <= {15'b0, cur.a[15]};
              res_cmp <= cur.a[15];
              state   <= S_DONE;
            end else if (alu_s[0]) begin
              res     <= 16'd1;
              res_cmp <= 1'b1;
              state   <= S_DONE;
            end else if (alu_zero) begin
              state <= S_CALL;
            end else begin
              res     <= 16'd0;
              res_cmp <= 1'b0;
              state   <= S_DONE;
            end
          end else begin
            res[15:8] <= alu_s;
            res_zero  <= zlo_q & alu_zero;
            res_carry <= alu_cout;
            res_cmp   <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done0 <= ~owner;
          done1 <= owner;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural byte alu, vector table, scoreboard queue
// checked on every done, plus contention and mid-operation reset sequences.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic            CLK = 1'b0;
  logic            RST;
  logic            req0, req1;
  logic [AC_N-1:0] op0, op1;
  logic [15:0]     a0, b0, a1, b1;
  logic            done0, done1;
  logic [15:0]     res;
  logic            res_zero, res_carry, res_cmp, busy;
  logic [AC_N-1:0] alu_cs;
  logic [7:0]      alu_a, alu_b, alu_s;
  logic            alu_cin, alu_zero, alu_cout;

  alu_arbiter dut (
    .CLK(CLK), .RST(RST), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .done0(done0), .done1(done1),
    .res(res), .res_zero(res_zero), .res_carry(res_carry), .res_cmp(res_cmp),
    .busy(busy), .alu_cs(alu_cs), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_s(alu_s), .alu_zero(alu_zero), .alu_cout(alu_cout)
  );

  always #5 CLK = ~CLK;

  // Byte alu: SB returns borrow on carry_out; LS is unsigned a<b with zero = equal.
  always_comb begin
    alu_s    = '0;
    alu_cout = 1'b0;
    case (alu_cs)
      AC_AD:   {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin};
      AC_SB:   {alu_cout, alu_s} = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, alu_cin};
      AC_OR:   alu_s = alu_a | alu_b;
      AC_LS:   alu_s = {7'b0, (alu_a < alu_b)};
      default: alu_s = alu_a & alu_b;
    endcase
    alu_zero = (alu_cs == AC_LS) ? (alu_a == alu_b) : (alu_s == 8'h00);
  end

  typedef struct {
    logic            who;
    logic [AC_N-1:0] op;
    logic [15:0]     a, b, res;
    logic            z, c, cmp, chk_cmp;
    int              lat;
  } vec_t;

  typedef struct {
    logic        who;
    logic [15:0] res;
    logic        z, c, cmp, chk_cmp;
  } exp_t;

  exp_t sb[$];
  vec_t vt[15];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.who = v.who; e.res = v.res; e.z = v.z; e.c = v.c;
    e.cmp = v.cmp; e.chk_cmp = v.chk_cmp;
    return e;
  endfunction

  // Scoreboard: every done pops the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && (done0 || done1)) begin
      exp_t e;
      chk("done one-hot", {31'b0, done0 & done1}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected done: done0=%b done1=%b at %0t", done0, done1, $time);
      end else begin
        e = sb.pop_front();
        chk("owner", {31'b0, done1}, {31'b0, e.who});
        chk("res", {16'b0, res}, {16'b0, e.res});
        chk("res_zero", {31'b0, res_zero}, {31'b0, e.z});
        chk("res_carry", {31'b0, res_carry}, {31'b0, e.c});
        if (e.chk_cmp) chk("res_cmp", {31'b0, res_cmp}, {31'b0, e.cmp});
      end
    end
  end

  task automatic drive(input vec_t v);
    if (v.who) begin req1 = 1'b1; op1 = v.op; a1 = v.a; b1 = v.b; end
    else       begin req0 = 1'b1; op0 = v.op; a0 = v.a; b0 = v.b; end
  endtask

  // Counts rising edges from the request to the done cycle, then drops req.
  task automatic wait_done(input vec_t v);
    int   n;
    logic got;
    n = 0; got = 1'b0;
    while (!got && n < 12) begin
      @(negedge CLK);
      n++;
      if (n == 1) chk("busy after grant", {31'b0, busy}, 32'd1);
      got = v.who ? done1 : done0;
    end
    if (v.who) req1 = 1'b0; else req0 = 1'b0;
    chk("done seen", {31'b0, got}, 32'd1);
    chk("latency", n, v.lat);
    @(negedge CLK);
    chk("busy idle", {31'b0, busy}, 32'd0);
  endtask

  task automatic run_op(input vec_t v);
    @(negedge CLK);
    drive(v);
    sb.push_back(to_exp(v));
    wait_done(v);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " res"}, {16'b0, res}, 32'd0);
    chk({nm, " flags"}, {29'b0, res_zero, res_carry, res_cmp}, 32'd0);
    chk({nm, " done/busy"}, {29'b0, done0, done1, busy}, 32'd0);
    chk({nm, " alu"}, {8'b0, alu_cs, alu_a, alu_b, alu_cin}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   t[4];
    int   cnt, cyc;
    //        who   op     a         b         res       z     c     cmp   chkc  lat
    vt[0]  = '{1'b0, AC_AD, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 4};
    vt[1]  = '{1'b1, AC_AD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4};
    vt[2]  = '{1'b0, AC_LS, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 3};
    vt[3]  = '{1'b1, AC_LS, 16'h1203, 16'h1205, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 4};
    vt[4]  = '{1'b0, AC_LS, 16'h1205, 16'h1205, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 4};
    vt[5]  = '{1'b0, AC_SB, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0, 4};
    vt[6]  = '{1'b1, AC_SB, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    vt[7]  = '{1'b0, AC_AN, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 4};
    vt[8]  = '{1'b1, AC_OR, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 4};
    vt[9]  = '{1'b0, AC_LS, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    vt[10] = '{1'b1, AC_LS, 16'h1300, 16'h12FF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    vt[11] = '{1'b0, AC_LS, 16'h1100, 16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 3};
    vt[12] = '{1'b1, 3'd7,  16'hFF0F, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 4};
    vt[13] = '{1'b0, AC_AN, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    vt[14] = '{1'b1, AC_SB, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4};

    RST = 1'b1; req0 = 1'b0; req1 = 1'b0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");
    RST = 1'b0;

    foreach (vt[i]) run_op(vt[i]);

    // Contention: both held with AND ops, fresh pointer favours req0.
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    req0 = 1'b1; op0 = AC_AN; a0 = 16'h00FF; b0 = 16'h0F0F;
    req1 = 1'b1; op1 = AC_AN; a1 = 16'hFF00; b1 = 16'hF0F0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0});
      sb.push_back('{1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    cnt = 0; cyc = 0;
    while (cnt < 4 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (done0 || done1) begin t[cnt] = cyc; cnt++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("contention done count", cnt, 4);
    if (cnt == 4) begin
      chk("contention first done", t[0], 4);
      for (int i = 1; i < 4; i++) chk("contention spacing", t[i] - t[i-1], 4);
    end
    @(negedge CLK);

    // Reset while in the high-byte pass, then a pending req1 alone.
    v = '{1'b0, AC_AD, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 4};
    drive(v);
    repeat (2) @(negedge CLK);
    chk("pre-reset busy", {31'b0, busy}, 32'd1);
    RST = 1'b1;
    req0 = 1'b0;
    v = '{1'b1, AC_OR, 16'hA000, 16'h000B, 16'hA00B, 1'b0, 1'b0, 1'b0, 1'b0, 4};
    drive(v);
    #1;
    chk_all_zero("mid-op reset");
    @(negedge CLK);
    chk_all_zero("held reset");
    sb.push_back(to_exp(v));
    RST = 1'b0;
    wait_done(v);

    repeat (3) @(negedge CLK);
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 8-bit `alu` between two 16-bit requesters, e.g. the keypad calculator path and a second command source. It arbitrates round-robin and latches the winner's operands. It then sequences the byte-slice ALU through low/high (or high/low for compare) passes and returns a registered 16-bit result with flags and a one-cycle done strobe to the winner. The block owns the ALU ports, so no other logic drives `alu` directly.

## Interface
- `AC_N`, from `ALU_INTERFACE.v`: opcode width; the `AC_AD`, `AC_SB`, `AC_AN`, `AC_OR`, `AC_LS` encodings are taken from the same file.
- `CLK`  in  1  system clock; all state changes on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1 each  request; held high with stable operands until the matching done.
- `op0`, `op1`  in  AC_N each  requested operation.
- `a0`, `b0`, `a1`, `b1`  in  16 each  operands A and B.
- `done0`, `done1`  out  1 each  one-cycle strobe: result valid for that requester.
- `res`  out  16  result, shared by both requesters; held until the next done.
- `res_zero`, `res_carry`, `res_cmp`  out  1 each  flags; held with `res`.
- `busy`  out  1  high from grant through the done cycle.
- `alu_cs`  out  AC_N  to `alu` `CS`.
- `alu_a`, `alu_b`  out  8  to `alu` `data_a`, `data_b`.
- `alu_cin`  out  1  to `alu` `carry_in`.
- `alu_s`  in  8  from `alu` `S`.
- `alu_zero`, `alu_cout`  in  1  from `alu` `zero`, `carry_out`.

## Operation
- States: `S_IDLE`, `S_CALL`, `S_CALH`, `S_DONE`.
- **`S_IDLE`**
  - If any request is high, grant one and latch `op`/`A`/`B` from the winner.
  - Record the owner and set `busy`.
  - Next state: `S_CALH` when the op is `AC_LS`, otherwise `S_CALL`.
  - Both requests high: grant the requester that did not win last; pointer resets to favour `req0`.
  - Pointer flips only on a grant.
- **`S_CALL`**: `alu_a`/`alu_b` = low bytes.
  - AD/SB/AN/OR: `alu_cin` = 0.
    - Write `res[7:0]` = `alu_s`; hold `alu_zero` and `alu_cout` in internal registers.
    - Go to `S_CALH`.
  - LS (arrived from `S_CALH`): `res` = {15'b0, `alu_s[0]`}, `res_cmp` = `alu_s[0]`; go to `S_DONE`.
- **`S_CALH`**: `alu_a`/`alu_b` = high bytes.
  - AD/SB/AN/OR: `alu_cin` = carry registered in `S_CALL`.
    - `res[15:8]` = `alu_s`.
    - `res_zero` = low zero AND `alu_zero`.
    - `res_carry` = `alu_cout`.
    - Go to `S_DONE`.
  - LS, `alu_cin` = 0:
    - If `A[15]` ≠ `B[15]`: `res` = `res_cmp` = `A[15]`; go to `S_DONE`.
    - Else if `alu_s[0]`: `res` = `res_cmp` = 1; go to `S_DONE`.
    - Else if `alu_zero` (high bytes equal): go to `S_CALL`.
    - Else: `res` = `res_cmp` = 0; go to `S_DONE`.
  - LS always forces `res_zero` = `res_carry` = 0.
- **`S_DONE`**: assert the owner's done for one cycle, clear `busy`, go to `S_IDLE`. No grant is made in this cycle.
- `alu_*` outputs are driven to 0 in `S_IDLE`/`S_DONE`; never x.
- An unknown opcode is treated as `AC_AN`.
- Requester rules:
  - The requester must drop `req` in the cycle after its done; a `req` still high in `S_IDLE` is a new request.
  - Changing operands while granted is illegal; the latched copy is used regardless.

## Timing
- The ALU is combinational; each pass takes one cycle.
- Request seen at edge k (in `S_IDLE`):
  - AD/SB/AN/OR: done high during the cycle after edge k+3.
  - LS decided in high byte: done after edge k+2.
  - LS needing low byte: done after edge k+3.
- Back-to-back throughput: one op per 4 cycles (3 for early-decided LS).
- Reset values: `res` = 0, all flags 0, `done0`/`done1` = 0, `busy` = 0, state `S_IDLE`, pointer favours `req0`, `alu_*` = 0.
- `RST` mid-operation aborts with no done issued; the requester must reissue.

## Structure
- `AC_*` opcodes and `AC_N` come from the shared `ALU_INTERFACE.v`.
- State encodings (`S_IDLE`..`S_DONE`) are local.
- No sub-module; the `alu` is instantiated by the parent and wired to the `alu_*` ports.

## Test plan
- **Add, single requester**: `req0`, AD, `A` = 0x00FF, `B` = 0x0001 → `done0` after 4 cycles, `res` = 0x0100, `res_carry` = 0, `res_zero` = 0.
- **Add, carry and zero**: `req1`, AD, `A` = 0xFFFF, `B` = 0x0001 → `res` = 0x0000, `res_zero` = 1, `res_carry` = 1, only `done1` pulses.
- **Compare, signs differ**: LS, `A` = 0x8000, `B` = 0x0001 → `res` = 1 and `res_cmp` = 1 after 3 cycles.
- **Compare, high bytes equal**:
  - `A` = 0x1203, `B` = 0x1205 → `res` = 1 after 4 cycles.
  - `A` = 0x1205, `B` = 0x1205 → `res` = 0 after 4 cycles.
- **Contention**: `req0`/`req1` both held high with AN ops.
  - Grants go 0,1,0,1.
  - Each done hits only the owner.
  - No grant is made in a `S_DONE` cycle.
- **Reset**: `RST` pulsed while in `S_CALH` → all outputs 0 immediately, no done; after release a pending `req1` is granted cleanly with `req0` idle.
